// File: rtl/rtype_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rtype_pkg: R-type funct codes, issue FSM states and field helpers (rev 1.0)
// ---------------------------------------------------------------------------
package rtype_pkg;

  localparam logic [5:0] c_FN_AND   = 6'd36;
  localparam logic [5:0] c_FN_OR    = 6'd37;
  localparam logic [5:0] c_FN_ADD   = 6'd32;
  localparam logic [5:0] c_FN_SUB   = 6'd34;
  localparam logic [5:0] c_FN_SLT   = 6'd42;
  localparam logic [5:0] c_FN_SLL   = 6'd0;
  localparam logic [5:0] c_FN_MULTU = 6'd25;
  localparam logic [5:0] c_FN_MFHI  = 6'd16;
  localparam logic [5:0] c_FN_MFLO  = 6'd18;

  localparam logic [5:0] c_NOP_CODE = 6'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MULT = 2'd2
  } state_e;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_f_t;

  function automatic instr_f_t fields(input logic [31:0] w);
    return instr_f_t'(w);
  endfunction

  function automatic logic is_legal(input instr_f_t f);
    logic fn_ok;
    fn_ok = (f.funct == c_FN_AND)  || (f.funct == c_FN_OR)    ||
            (f.funct == c_FN_ADD)  || (f.funct == c_FN_SUB)   ||
            (f.funct == c_FN_SLT)  || (f.funct == c_FN_SLL)   ||
            (f.funct == c_FN_MULTU)|| (f.funct == c_FN_MFHI)  ||
            (f.funct == c_FN_MFLO);
    return (f.op == 6'd0) && fn_ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtype_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rtype_regfile: 32x32 register file, 2 read + 1 debug read + 1 write, R0 = 0 (rev 1.0)
// ---------------------------------------------------------------------------
module rtype_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra_addr_i,
  output logic [31:0] ra_data_o,
  input  logic [4:0]  rb_addr_i,
  output logic [31:0] rb_data_o,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] mem_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (wa_i != 5'd0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Entry 0 is never written, but the read mux still forces zero explicitly.
  assign ra_data_o  = (ra_addr_i  == 5'd0) ? 32'd0 : mem_q[ra_addr_i];
  assign rb_data_o  = (rb_addr_i  == 5'd0) ? 32'd0 : mem_q[rb_addr_i];
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? 32'd0 : mem_q[dbg_addr_i];

endmodule
`default_nettype wire

// File: rtl/rtype_issue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rtype_issue: single-issue R-type front end feeding the TotalALU (rev 1.0)
// ---------------------------------------------------------------------------
module rtype_issue #(
  parameter int         MULTU_CYCLES = 32,
  parameter logic [5:0] NOP_CODE     = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [5:0]  Signal,
  input  logic [31:0] aluOut,
  output logic        busy,
  output logic        illegal,
  output logic [15:0] retired,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  import rtype_pkg::*;

  localparam int               CNT_W      = (MULTU_CYCLES > 1) ? $clog2(MULTU_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MULTU_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_a_q, data_a_d;
  logic [31:0]      data_b_q, data_b_d;
  logic [5:0]       signal_q, signal_d;
  logic [4:0]       rd_q, rd_d;
  logic             illegal_q, illegal_d;
  logic [15:0]      retired_q, retired_d;

  instr_f_t    w_f;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic        w_fire;
  logic        w_wb_en;

  assign w_f         = fields(instr);
  assign instr_ready = (state_q == IDLE);
  assign w_fire      = instr_valid && instr_ready;
  assign w_wb_en     = (state_q == EXEC);

  rtype_regfile u_rf (
    .clk        (clk),
    .rst_n      (reset),
    .ra_addr_i  (w_f.rs),
    .ra_data_o  (w_rs_data),
    .rb_addr_i  (w_f.rt),
    .rb_data_o  (w_rt_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data),
    .we_i       (w_wb_en),
    .wa_i       (rd_q),
    .wd_i       (aluOut)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      signal_q  <= NOP_CODE;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      signal_q  <= signal_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_a_d  = '0;
    data_b_d  = '0;
    signal_d  = NOP_CODE;
    rd_d      = rd_q;
    illegal_d = 1'b0;
    retired_d = retired_q;

    case (state_q)
      IDLE: begin
        if (w_fire) begin
          if (is_legal(w_f)) begin
            signal_d = w_f.funct;
            rd_d     = w_f.rd;
            if (w_f.funct == c_FN_SLL) begin
              data_a_d = w_rt_data;
              data_b_d = {27'd0, w_f.shamt};
            end else if ((w_f.funct != c_FN_MFHI) && (w_f.funct != c_FN_MFLO)) begin
              data_a_d = w_rs_data;
              data_b_d = w_rt_data;
            end
            if (w_f.funct == c_FN_MULTU) begin
              state_d = MULT;
              cnt_d   = c_CNT_LOAD;
            end else begin
              state_d = EXEC;
            end
          end else begin
            illegal_d = 1'b1;
          end
        end
      end

      EXEC: begin
        state_d   = IDLE;
        retired_d = retired_q + 16'd1;
      end

      MULT: begin
        // Operands and function code stay presented for the whole multiply window.
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        signal_d = signal_q;
        if (cnt_q == '0) begin
          state_d   = IDLE;
          retired_d = retired_q + 16'd1;
          data_a_d  = '0;
          data_b_d  = '0;
          signal_d  = NOP_CODE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dataA   = data_a_q;
  assign dataB   = data_b_q;
  assign Signal  = signal_q;
  assign busy    = (state_q != IDLE);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_rtype_issue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rtype_issue: randomized scoreboard bench for rtype_issue (rev 1.0)
// ---------------------------------------------------------------------------
module tb_rtype_issue;

  localparam int         MC  = 32;
  localparam logic [5:0] NOP = 6'h3F;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] aluOut;
  logic        busy;
  logic        illegal;
  logic [15:0] retired;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  rtype_issue #(.MULTU_CYCLES(MC), .NOP_CODE(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .dataA       (dataA),
    .dataB       (dataB),
    .Signal      (Signal),
    .aluOut      (aluOut),
    .busy        (busy),
    .illegal     (illegal),
    .retired     (retired),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  typedef struct {
    bit          ill;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sig;
    int          len;
    logic [4:0]  rd;
    logic [31:0] rdval;
    logic [15:0] ret;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_rf [32];
  logic [15:0] m_ret;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          mon_ready, stim_done, mon_done, rst_test_done, mon_done2;
  bit          mon_in_flight, aborted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] rand_word();
    int         k;
    logic [5:0] fn;
    logic [5:0] op;
    k  = int'($urandom_range(0, 23));
    op = 6'd0;
    case (k)
      0, 1:       fn = 6'd25;
      2:          begin op = 6'($urandom_range(1, 63)); fn = 6'd32; end
      3:          fn = 6'h3E;
      4, 5:       fn = 6'd16;
      6:          fn = 6'd18;
      7, 8:       fn = 6'd0;
      9, 10:      fn = 6'd36;
      11, 12:     fn = 6'd37;
      13, 14, 15: fn = 6'd34;
      16, 17:     fn = 6'd42;
      default:    fn = 6'd32;
    endcase
    return mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom), fn);
  endfunction

  // Architectural reference: what the ALU should see and what the register file holds afterwards.
  task automatic model_issue(input logic [31:0] w, input logic [31:0] alu, output exp_t e);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh;
    {op, rs, rt, rd, sh, fn} = w;
    e.rd  = rd;
    e.a   = 32'd0;
    e.b   = 32'd0;
    e.sig = NOP;
    e.len = 0;
    if ((op != 6'd0) || !(fn inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0, 6'd25, 6'd16, 6'd18})) begin
      e.ill = 1'b1;
    end else begin
      e.ill = 1'b0;
      e.sig = fn;
      if (fn == 6'd0) begin
        e.a = m_rf[rt];
        e.b = 32'(sh);
      end else if ((fn != 6'd16) && (fn != 6'd18)) begin
        e.a = m_rf[rs];
        e.b = m_rf[rt];
      end
      if (fn == 6'd25) begin
        e.len = MC;
      end else begin
        e.len = 1;
        if (rd != 5'd0) m_rf[rd] = alu;
      end
      m_ret = m_ret + 16'd1;
    end
    e.rdval = m_rf[rd];
    e.ret   = m_ret;
  endtask

  task automatic issue(input logic [31:0] w, input logic [31:0] alu);
    exp_t e;
    int   waitc;
    if (!aborted) begin
      waitc       = 0;
      instr_valid = 1'b1;
      instr       = w;
      @(negedge clk);
      while (!instr_ready && waitc < 200) begin
        waitc++;
        @(negedge clk);
      end
      if (!instr_ready) begin
        chk("issue_ready_timeout", {31'd0, instr_ready}, 32'd1);
        aborted     = 1'b1;
        instr_valid = 1'b0;
      end else begin
        aluOut = alu;
        model_issue(w, alu, e);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
      end
    end
  endtask

  // Stimulus
  initial begin
    int waitc;
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    aluOut      = 32'd0;
    m_ret       = 16'd0;
    aborted     = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_signal", {26'd0, Signal}, {26'd0, NOP});
    chk("rst_dataA", dataA, 32'd0);
    chk("rst_dataB", dataB, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_retired", {16'd0, retired}, 32'd0);
    waitc = 0;
    while (!mon_ready && waitc < 100) begin waitc++; @(negedge clk); end
    @(posedge clk);
    #1;

    issue(mk(6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'd32), 32'd5);
    issue(mk(6'd0, 5'd0, 5'd0, 5'd2, 5'd0, 6'd32), 32'd7);
    issue(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'd32), 32'd12);
    issue(mk(6'd0, 5'd0, 5'd1, 5'd4, 5'd3, 6'd0), 32'd40);
    issue(mk(6'd0, 5'd3, 5'd4, 5'd0, 5'd0, 6'd32), 32'd99);
    issue(mk(6'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'd25), 32'hDEAD_BEEF);
    issue(mk(6'd0, 5'd1, 5'd1, 5'd6, 5'd0, 6'd32), 32'd10);
    issue(mk(6'd0, 5'd0, 5'd0, 5'd7, 5'd0, 6'd16), 32'h1234);
    issue(32'hFC00_0020, 32'h5555);
    issue(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3E), 32'h6666);

    for (int n = 0; n < 150; n++) begin
      if (aborted) break;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      issue(rand_word(), $urandom);
    end

    waitc = 0;
    while ((sbq.size() != 0 || mon_in_flight || busy) && waitc < 300) begin
      waitc++;
      @(negedge clk);
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge clk);
    stim_done = 1'b1;
    waitc = 0;
    while (!mon_done && waitc < 200) begin waitc++; @(negedge clk); end

    // Abort a multiply mid-window with the asynchronous reset.
    @(posedge clk);
    #1;
    instr       = mk(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'd25);
    instr_valid = 1'b1;
    waitc = 0;
    @(negedge clk);
    while (!instr_ready && waitc < 100) begin waitc++; @(negedge clk); end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("mult_busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_signal", {26'd0, Signal}, {26'd0, NOP});
    chk("abort_dataA", dataA, 32'd0);
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_retired", {16'd0, retired}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("post_rst_retired", {16'd0, retired}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    rst_test_done = 1'b1;
    waitc = 0;
    while (!mon_done2 && waitc < 200) begin waitc++; @(negedge clk); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Monitor: pops one expectation per illegal pulse or per busy window.
  initial begin
    exp_t cur;
    int   run;
    bit   sig_ok, rdy_ok, prev_busy, idle_bad;
    dbg_addr      = 5'd0;
    prev_busy     = 1'b0;
    idle_bad      = 1'b0;
    mon_in_flight = 1'b0;
    wait (reset === 1'b1);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("rst_rf[%0d]", i), dbg_data, 32'd0);
    end
    mon_ready = 1'b1;
    while (!stim_done) begin
      @(negedge clk);
      if (illegal) begin
        if (sbq.size() == 0) begin
          chk("illegal_unexpected", 32'd1, 32'd0);
        end else begin
          cur = sbq.pop_front();
          chk("illegal_kind", 32'd1, {31'd0, cur.ill});
          chk("illegal_retired", {16'd0, retired}, {16'd0, cur.ret});
          dbg_addr = cur.rd;
          #1;
          chk("illegal_rf_unchanged", dbg_data, cur.rdval);
        end
      end
      if (busy && !prev_busy) begin
        if (sbq.size() == 0) begin
          chk("busy_unexpected", 32'd1, 32'd0);
        end else begin
          cur = sbq.pop_front();
          mon_in_flight = 1'b1;
          chk("op_kind_legal", {31'd0, cur.ill}, 32'd0);
          chk("op_dataA", dataA, cur.a);
          chk("op_dataB", dataB, cur.b);
          chk("op_signal", {26'd0, Signal}, {26'd0, cur.sig});
          run    = 1;
          sig_ok = 1'b1;
          rdy_ok = !instr_ready;
        end
      end else if (busy && prev_busy) begin
        run++;
        if (Signal !== cur.sig) sig_ok = 1'b0;
        if (instr_ready) rdy_ok = 1'b0;
      end else if (!busy && prev_busy && mon_in_flight) begin
        chk("op_length", 32'(run), 32'(cur.len));
        chk("op_signal_held", {31'd0, sig_ok}, 32'd1);
        chk("op_ready_low", {31'd0, rdy_ok}, 32'd1);
        chk("op_retired", {16'd0, retired}, {16'd0, cur.ret});
        dbg_addr = cur.rd;
        #1;
        chk("op_rf_rd", dbg_data, cur.rdval);
        mon_in_flight = 1'b0;
      end
      if (!busy && ((Signal !== NOP) || (dataA !== 32'd0) || (dataB !== 32'd0))) idle_bad = 1'b1;
      prev_busy = busy;
    end
    chk("idle_outputs", {31'd0, idle_bad}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("final_rf[%0d]", i), dbg_data, m_rf[i]);
    end
    mon_done = 1'b1;
    wait (rst_test_done);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("abort_rf[%0d]", i), dbg_data, 32'd0);
    end
    mon_done2 = 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/rtype_issue.md
# rtype_issue

Single-issue front end that sits directly upstream of the TotalALU execution block. It accepts MIPS R-type instruction words over a valid/ready handshake and reads operands from an internal 32x32 register file. It drives dataA/dataB/Signal into the ALU, sequences the multi-cycle MULTU window, and writes the ALU Output back to rd.

## Interface
Parameters:
- MULTU_CYCLES, 32, number of cycles Signal is held at MULTU for one multiply (must be ≥1)
- NOP_CODE, 6'b111111, Signal value driven when no operation is in execution

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears all state
- instr_valid  input  1  instr holds a valid word
- instr  input  32  instruction: [31:26] op, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct
- instr_ready  output  1  block can accept instr this cycle
- dataA  output  32  ALU operand A (registered)
- dataB  output  32  ALU operand B (registered)
- Signal  output  6  ALU function code (registered)
- aluOut  input  32  TotalALU Output, sampled in EXEC
- busy  output  1  state ≠ IDLE
- illegal  output  1  one-cycle pulse on a dropped instruction
- retired  output  16  count of written-back or completed instructions, wraps
- dbg_addr  input  5  register-file debug read address
- dbg_data  output  32  combinational read of R[dbg_addr]; R0 reads 0

## Operation
- Legal only when op==0 and funct ∈ {AND 36, OR 37, ADD 32, SUB 34, SLT 42, SLL 0, MULTU 25, MFHI 16, MFLO 18}.
- An illegal word is consumed in IDLE with no state change other than a pulse on illegal the next cycle. It is not counted in retired.
- Operands:
  - SLL: dataA=R[rt], dataB={27'b0,shamt}.
  - MFHI/MFLO: dataA=dataB=0.
  - All other ops: dataA=R[rs], dataB=R[rt].
- Signal=funct for every legal op.
- FSM states: IDLE, EXEC, MULT.
  - IDLE: instr_ready=1. On handshake with a legal non-MULTU word, go to EXEC. On MULTU, go to MULT with cnt=MULTU_CYCLES-1.
  - EXEC: lasts one cycle. At its closing edge, R[rd]←aluOut (suppressed if rd==0), retired+1, go to IDLE.
  - MULT: no writeback. cnt decrements each cycle. When cnt==0, the closing edge returns to IDLE with retired+1.
- In IDLE the outputs are dataA=dataB=0 and Signal=NOP_CODE.
- R0 is never written and always reads 0.
- Single issue and in-order. MFHI/MFLO can only issue after MULT completes, so no hazard logic is required.

## Timing
- Reset values: instr_ready=1 and Signal=NOP_CODE. All of the following are 0: dataA, dataB, busy, illegal, retired, cnt, every register-file entry.
- Handshake at edge T (valid&ready) causes the following:
  - operands and Signal are valid from T to T+1;
  - for ALU ops and MF ops, the write to R[rd] lands at edge T+1 and instr_ready=1 again after T+1;
  - for MULTU, Signal=MULTU holds for exactly MULTU_CYCLES cycles, and instr_ready returns after T+MULTU_CYCLES.
- Throughput: one ALU op every 2 cycles; one MULTU every MULTU_CYCLES+1 cycles.
- instr_ready=0 in EXEC and MULT. The upstream must hold instr stable while valid&!ready.
- Register reads happen at handshake time. A write at edge T+1 is therefore visible to an instruction accepted at edge ≥T+2.
- An asynchronous reset during MULT or EXEC aborts the operation:
  - no writeback occurs;
  - the FSM returns to IDLE and all outputs return to their reset values immediately.
- retired wraps from 16'hFFFF to 0.

## Structure
- Shared package rtype_pkg holds:
  - funct constants: AND, OR, ADD, SUB, SLT, SLL, MULTU, MFHI, MFLO;
  - NOP_CODE;
  - the state enum {IDLE, EXEC, MULT};
  - a field-extract helper for op/rs/rt/rd/shamt/funct.
- One sub-module, rtype_regfile: 32x32 storage with 2 combinational read ports, 1 debug read port and 1 synchronous write port, R0 hardwired to zero, asynchronous active-low clear.
- FSM, decode and the multiply counter stay in rtype_issue.

## Test plan
- Reset, then hold valid low: instr_ready=1, Signal=6'h3F, dataA=0, retired=0, dbg_data=0 for all addresses.
- Preload R1=5 and R2=7 via ADD-from-R0 sequences stubbed with aluOut. Issue ADD rd=3 rs=1 rt=2: EXEC shows dataA=5, dataB=7, Signal=32. Return aluOut=12; R3=12 after T+1; retired increments by 1.
- Issue SLL rd=4 rt=1 shamt=3: dataA=5, dataB=3, Signal=0. Issue an ADD with rd=0: R0 stays 0.
- Issue MULTU with MULTU_CYCLES=32 while holding a second valid word: Signal=25 for exactly 32 cycles and instr_ready=0 throughout. The second word is accepted on the 33rd edge, and no register-file write occurs for the MULTU.
- Issue instr=32'hFC000020 (op≠0), then funct=6'h3E: each is consumed in 1 cycle, illegal pulses once each, retired is unchanged, and the register file is unchanged.
- Assert reset in cycle 10 of MULT: busy drops and Signal=6'h3F immediately. After release, instr_ready=1 and retired=0.
